sprite_compositor: RTL and testbench

//  Parametrised successor of the single-dog colour mapper: composites one background plus NUM_SPR

---
 rtl/sprite_compositor.sv | 135 +++++++++++++
 tb/tb_sprite_compositor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// sprite_compositor: background + NUM_SPR sprites, fixed priority, index-0 transparency, 4:4:4 RGB out; optional diamond cursor when CURSOR_EN is defined
module sprite_compositor #(
    parameter int NUM_SPR = 2,
    parameter int SPR_W   = 110,
    parameter int SPR_H   = 86,
    parameter int ADDR_W  = 14,
    parameter int ROM_LAT = 1
) (
    input  logic                      vga_clk,
    input  logic                      Reset,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic                      blank,
    input  logic [10*NUM_SPR-1:0]     SprX,
    input  logic [10*NUM_SPR-1:0]     SprY,
    input  logic [NUM_SPR-1:0]        SprEn,
    output logic [ADDR_W*NUM_SPR-1:0] spr_addr,
    input  logic [4*NUM_SPR-1:0]      spr_idx,
    input  logic [12*NUM_SPR-1:0]     spr_rgb,
    input  logic [11:0]               bg_rgb,
`ifdef CURSOR_EN
    input  logic [9:0]                CurX,
    input  logic [9:0]                CurY,
    input  logic [9:0]                CurSize,
`endif
    output logic [7:0]                frame_cnt,
    output logic [3:0]                Red,
    output logic [3:0]                Green,
    output logic [3:0]                Blue
);
    logic [10*NUM_SPR-1:0]     lat_x, lat_y;
    logic [NUM_SPR-1:0]        lat_en;
    logic [NUM_SPR-1:0]        hit_c, hit_a;
    logic [ADDR_W*NUM_SPR-1:0] addr_c;
    logic                      blank_a, cur_c, cur_a;
    logic [NUM_SPR-1:0]        hit_d [ROM_LAT];
    logic [ROM_LAT-1:0]        blank_d, cur_d;
    logic [11:0]               rgb_c, rgb_q;

    // Shadow sprite state captured only at the first pixel of a frame so motion never tears
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            lat_x     <= '0;
            lat_y     <= '0;
            lat_en    <= '0;
            frame_cnt <= '0;
        end else if (DrawX == 10'd0 && DrawY == 10'd0) begin
            lat_x     <= SprX;
            lat_y     <= SprY;
            lat_en    <= SprEn;
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Per-sprite rectangle hit test in 11 bits so a sprite near the right edge cannot wrap to column 0
    always_comb begin
        hit_c  = '0;
        addr_c = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            hit_c[i] = lat_en[i]
                && {1'b0, DrawX} >= {1'b0, lat_x[10*i +: 10]}
                && {1'b0, DrawX} <  {1'b0, lat_x[10*i +: 10]} + 11'(SPR_W)
                && {1'b0, DrawY} >= {1'b0, lat_y[10*i +: 10]}
                && {1'b0, DrawY} <  {1'b0, lat_y[10*i +: 10]} + 11'(SPR_H);
            addr_c[ADDR_W*i +: ADDR_W] = hit_c[i]
                ? ADDR_W'(32'(DrawY - lat_y[10*i +: 10]) * SPR_W + 32'(DrawX - lat_x[10*i +: 10]))
                : '0;
        end
    end

`ifdef CURSOR_EN
    logic signed [10:0] cur_dx, cur_dy;
    logic [11:0]        cur_dist;

    // Manhattan distance from the cursor centre; inside the diamond when it does not exceed CurSize
    always_comb begin
        cur_dx   = $signed({1'b0, DrawX}) - $signed({1'b0, CurX});
        cur_dy   = $signed({1'b0, DrawY}) - $signed({1'b0, CurY});
        cur_dist = 12'(cur_dx < 0 ? -cur_dx : cur_dx) + 12'(cur_dy < 0 ? -cur_dy : cur_dy);
        cur_c    = cur_dist <= {2'b00, CurSize};
    end
`else
    assign cur_c = 1'b0;
`endif

    // Stage A: register ROM addresses and the per-pixel flags that travel with them
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            spr_addr <= '0;
            hit_a    <= '0;
            blank_a  <= 1'b0;
            cur_a    <= 1'b0;
        end else begin
            spr_addr <= addr_c;
            hit_a    <= hit_c;
            blank_a  <= blank;
            cur_a    <= cur_c;
        end
    end

    // Delay the flags by the ROM latency so they line up with spr_idx/spr_rgb/bg_rgb
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < ROM_LAT; k++) hit_d[k] <= '0;
            blank_d <= '0;
            cur_d   <= '0;
        end else begin
            hit_d[0]   <= hit_a;
            blank_d[0] <= blank_a;
            cur_d[0]   <= cur_a;
            for (int k = 1; k < ROM_LAT; k++) begin
                hit_d[k]   <= hit_d[k-1];
                blank_d[k] <= blank_d[k-1];
                cur_d[k]   <= cur_d[k-1];
            end
        end
    end

    // Stage C: scan from lowest priority up so the lowest-index opaque sprite ends up on top
    always_comb begin
        rgb_c = bg_rgb;
        for (int i = NUM_SPR - 1; i >= 0; i--)
            if (hit_d[ROM_LAT-1][i] && spr_idx[4*i +: 4] != 4'd0) rgb_c = spr_rgb[12*i +: 12];
        if (cur_d[ROM_LAT-1]) rgb_c = 12'hFFF;
        if (!blank_d[ROM_LAT-1]) rgb_c = '0;
    end

    // Registered colour output, forced black while reset is asserted
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) rgb_q <= '0;
        else rgb_q <= rgb_c;
    end

    assign {Red, Green, Blue} = rgb_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: scoreboard bench for sprite_compositor with a behavioural ROM and palette
module tb_sprite_compositor;
    localparam int LAT = 3;

    logic        vga_clk = 1'b0;
    logic        Reset   = 1'b1;
    logic [9:0]  DrawX   = '0;
    logic [9:0]  DrawY   = '0;
    logic        blank   = 1'b0;
    logic [19:0] SprX    = '0;
    logic [19:0] SprY    = '0;
    logic [1:0]  SprEn   = '0;
    logic [27:0] spr_addr;
    logic [7:0]  spr_idx = '0;
    logic [23:0] spr_rgb;
    logic [11:0] bg_rgb  = 12'h123;
    logic [7:0]  frame_cnt;
    logic [3:0]  Red, Green, Blue;
`ifdef CURSOR_EN
    logic [9:0]  CurX    = 10'd1023;
    logic [9:0]  CurY    = 10'd1023;
    logic [9:0]  CurSize = 10'd0;
`endif

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } ent_t;

    ent_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          lx[2], ly[2], val[2], hole[2];
    bit          len[2], pat[2];
    int          exp_fc, px, py;
    logic [27:0] exp_addr;
    bit          have_prev;

    sprite_compositor dut (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .SprX(SprX), .SprY(SprY), .SprEn(SprEn), .spr_addr(spr_addr), .spr_idx(spr_idx),
        .spr_rgb(spr_rgb), .bg_rgb(bg_rgb),
`ifdef CURSOR_EN
        .CurX(CurX), .CurY(CurY), .CurSize(CurSize),
`endif
        .frame_cnt(frame_cnt), .Red(Red), .Green(Green), .Blue(Blue)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [11:0] pal(input int i, input logic [3:0] idx);
        return {idx, 4'(i + 1), ~idx};
    endfunction

    function automatic logic [3:0] rom_val(input int i, input int a);
        if (a == hole[i]) return 4'd0;
        return pat[i] ? 4'(a % 15 + 1) : 4'(val[i]);
    endfunction

    // One-cycle sprite ROM
    always @(posedge vga_clk)
        for (int i = 0; i < 2; i++) spr_idx[4*i +: 4] <= rom_val(i, int'(spr_addr[14*i +: 14]));

    // Palette lookup
    always_comb begin
        spr_rgb = '0;
        for (int i = 0; i < 2; i++) spr_rgb[12*i +: 12] = pal(i, spr_idx[4*i +: 4]);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model(input int x, input int y, input bit b,
                                  output logic [11:0] r, output logic [27:0] a);
        bit found = 0;
        logic [3:0] id;
        int ad;
        r = bg_rgb;
        a = '0;
        for (int i = 0; i < 2; i++)
            if (len[i] && x >= lx[i] && x < lx[i] + 110 && y >= ly[i] && y < ly[i] + 86) begin
                ad = (y - ly[i]) * 110 + (x - lx[i]);
                a[14*i +: 14] = 14'(ad);
                id = rom_val(i, ad);
                if (!found && id != 4'd0) begin
                    r = pal(i, id);
                    found = 1;
                end
            end
`ifdef CURSOR_EN
        if ((x > int'(CurX) ? x - int'(CurX) : int'(CurX) - x) +
            (y > int'(CurY) ? y - int'(CurY) : int'(CurY) - y) <= int'(CurSize)) r = 12'hFFF;
`endif
        if (!b) r = '0;
    endfunction

    task automatic step(input int x, input int y, input bit b);
        ent_t e;
        logic [11:0] r;
        logic [27:0] a;
        @(negedge vga_clk);
        if (q.size() == LAT) begin
            e = q.pop_front();
            chk($sformatf("rgb(%0d,%0d)", e.x, e.y), 32'({Red, Green, Blue}), 32'(e.rgb));
        end
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        if (have_prev) chk($sformatf("addr(%0d,%0d)", px, py), 32'(spr_addr), 32'(exp_addr));
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        model(x, y, b, r, a);
        e.x = 10'(x);
        e.y = 10'(y);
        e.rgb = r;
        q.push_back(e);
        exp_addr = a;
        px = x;
        py = y;
        have_prev = 1;
        if (x == 0 && y == 0) begin
            for (int i = 0; i < 2; i++) begin
                lx[i]  = int'(SprX[10*i +: 10]);
                ly[i]  = int'(SprY[10*i +: 10]);
                len[i] = SprEn[i];
            end
            exp_fc = (exp_fc + 1) % 256;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(639, 479, 0);
    endtask

    task automatic reset_sweep(input int n);
        Reset = 1'b1;
        q.delete();
        have_prev = 0;
        exp_fc = 0;
        lx = '{0, 0};
        ly = '{0, 0};
        len = '{0, 0};
        for (int k = 0; k < n; k++) begin
            @(negedge vga_clk);
            chk("rst_rgb", 32'({Red, Green, Blue}), 32'd0);
            chk("rst_addr", 32'(spr_addr), 32'd0);
            chk("rst_fc", 32'(frame_cnt), 32'd0);
            DrawX = 10'(k * 37 % 640);
            DrawY = 10'(k * 11 % 480);
            blank = 1'b1;
        end
        @(negedge vga_clk);
        Reset = 1'b0;
        DrawX = 10'd639;
        DrawY = 10'd479;
        blank = 1'b0;
    endtask

    initial begin
        hole = '{-1, -1};
        val  = '{0, 0};
        pat  = '{0, 0};
        reset_sweep(12);
        // single sprite at (100,50), solid index 3
        SprX  = {10'd400, 10'd100};
        SprY  = {10'd300, 10'd50};
        SprEn = 2'b01;
        val   = '{3, 5};
        idle(3);
        step(0, 0, 1);
        step(100, 50, 1);
        step(209, 135, 1);
        step(210, 50, 1);
        step(99, 50, 1);
        step(100, 49, 1);
        step(209, 136, 1);
        step(150, 100, 1);
        idle(3);
        // overlap with a transparent hole in sprite 0
        SprX    = {10'd200, 10'd200};
        SprY    = {10'd200, 10'd200};
        SprEn   = 2'b11;
        hole[0] = 555;
        step(0, 0, 1);
        step(205, 205, 1);
        step(206, 205, 1);
        step(205, 206, 1);
        step(199, 205, 1);
        step(309, 285, 1);
        step(310, 285, 1);
        idle(3);
        // address-dependent ROM content, partially overlapping sprites
        hole[0] = -1;
        pat     = '{1, 1};
        SprX[19:10] = 10'd250;
        SprY[19:10] = 10'd220;
        step(0, 0, 1);
        for (int x = 190; x <= 370; x += 3) step(x, 230, 1);
        for (int y = 195; y <= 310; y += 4) step(260, y, 1);
        idle(3);
        // mid-frame position change is deferred to the next frame
        pat   = '{0, 0};
        SprEn = 2'b01;
        SprX[9:0] = 10'd100;
        SprY[9:0] = 10'd50;
        step(0, 0, 1);
        step(150, 100, 1);
        SprX[9:0] = 10'd300;
        step(150, 100, 1);
        step(300, 100, 1);
        step(0, 0, 1);
        step(150, 100, 1);
        step(300, 100, 1);
        for (int k = 0; k < 258; k++) step(0, 0, 0);
        // blanking and right-edge clipping
        step(310, 60, 0);
        step(310, 60, 1);
        idle(3);
        pat[0] = 1;
        SprX[9:0] = 10'd600;
        SprY[9:0] = 10'd10;
        step(0, 0, 1);
        for (int x = 590; x < 640; x += 2) step(x, 20, 1);
        for (int x = 0; x < 76; x += 3) step(x, 20, 1);
        step(639, 95, 1);
        step(639, 96, 1);
        // asynchronous reset in the middle of a visible run
        step(610, 20, 1);
        step(611, 20, 1);
        step(612, 20, 1);
        #2 Reset = 1'b1;
        #1;
        chk("async_rgb", 32'({Red, Green, Blue}), 32'd0);
        chk("async_addr", 32'(spr_addr), 32'd0);
        chk("async_fc", 32'(frame_cnt), 32'd0);
        reset_sweep(4);
        step(0, 0, 1);
        step(605, 25, 1);
        step(620, 30, 1);
        idle(3);
`ifdef CURSOR_EN
        pat     = '{0, 0};
        val     = '{3, 5};
        SprX[9:0] = 10'd300;
        SprY[9:0] = 10'd200;
        SprEn   = 2'b01;
        CurX    = 10'd320;
        CurY    = 10'd240;
        CurSize = 10'd4;
        step(0, 0, 1);
        step(324, 240, 1);
        step(323, 242, 1);
        step(318, 242, 1);
        step(325, 240, 1);
        step(320, 236, 1);
        idle(3);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
